// File: rtl/mem_scan_ctrl.sv
// Range-scan sequencer sharing the single-port data memory with the CPU; finds the unsigned max byte and its address.
// Latency: count READ cycles + 2 write cycles + 1 DONE cycle after start; CPU accesses pass through with zero latency.
// Backpressure: cpu_req wins the port every cycle; the scan FSM and all its registers freeze while the CPU holds it.
module mem_scan_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] base_addr,
  input  logic [7:0] count,
  input  logic [7:0] result_addr,
  input  logic       cpu_req,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_read,
  input  logic       cpu_write,
  output logic       cpu_gnt,
  output logic [7:0] cpu_rdata,
  output logic [7:0] mem_address,
  output logic [7:0] mem_write_data,
  output logic       mem_read,
  output logic       mem_write,
  input  logic [7:0] mem_read_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] max_value,
  output logic [7:0] max_index
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WR_VAL = 3'd2,
    S_WR_IDX = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] base_q, base_d;
  logic [7:0] count_q, count_d;
  logic [7:0] res_q, res_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] max_val_q, max_val_d;
  logic [7:0] max_idx_q, max_idx_d;

  // Current scan address and the second result slot both wrap modulo 256.
  logic [7:0] scan_addr;
  logic [7:0] res_addr_hi;
  logic [7:0] last_idx;
  logic       new_max;

  assign scan_addr   = base_q + idx_q;
  assign res_addr_hi = res_q + 8'd1;
  assign last_idx    = count_q - 8'd1;
  assign new_max     = (mem_read_data > max_val_q);

  // The CPU side is a pure pass-through: grant is immediate and read data is the raw memory output.
  assign cpu_gnt   = cpu_req;
  assign cpu_rdata = mem_read_data;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign max_value = max_val_q;
  assign max_index = max_idx_q;

  // State and datapath registers; synchronous reset abandons any scan in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= 8'd0;
      count_q   <= 8'd0;
      res_q     <= 8'd0;
      idx_q     <= 8'd0;
      max_val_q <= 8'd0;
      max_idx_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      res_q     <= res_d;
      idx_q     <= idx_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
    end
  end

  // Next-state logic; a CPU request freezes everything, including start acceptance in IDLE.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    res_d     = res_q;
    idx_d     = idx_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;

    if (!cpu_req) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_d    = base_addr;
            count_d   = count;
            res_d     = result_addr;
            idx_d     = 8'd0;
            max_val_d = 8'd0;
            // An empty range still reports base_addr as the index of the (zero) maximum.
            max_idx_d = base_addr;
            state_d   = (count == 8'd0) ? S_WR_VAL : S_READ;
          end
        end
        S_READ: begin
          // Strict compare so equal values keep the earliest address.
          if (new_max) begin
            max_val_d = mem_read_data;
            max_idx_d = scan_addr;
          end
          idx_d = idx_q + 8'd1;
          if (idx_q == last_idx) begin
            state_d = S_WR_VAL;
          end
        end
        S_WR_VAL: state_d = S_WR_IDX;
        S_WR_IDX: state_d = S_DONE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Memory port mux: CPU first, then the scan access of the current state, otherwise all zeros.
  always_comb begin
    mem_address    = 8'd0;
    mem_write_data = 8'd0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;

    if (cpu_req) begin
      mem_address    = cpu_addr;
      mem_write_data = cpu_wdata;
      mem_read       = cpu_read;
      mem_write      = cpu_write;
    end else begin
      case (state_q)
        S_READ: begin
          mem_read    = 1'b1;
          mem_address = scan_addr;
        end
        S_WR_VAL: begin
          mem_write      = 1'b1;
          mem_address    = res_q;
          mem_write_data = max_val_q;
        end
        S_WR_IDX: begin
          mem_write      = 1'b1;
          mem_address    = res_addr_hi;
          mem_write_data = max_idx_q;
        end
        default: begin
          mem_read  = 1'b0;
          mem_write = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Directed bench for mem_scan_ctrl with a behavioural 256-byte memory behind the port.
// Cycle 0 is the cycle start is presented in IDLE; outputs are sampled 1 time unit after each rising edge.
// Every check is an immediate assertion that counts and reports its failure.
module tb_mem_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr, count, result_addr;
  logic       cpu_req;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_read, cpu_write;
  logic       cpu_gnt;
  logic [7:0] cpu_rdata;
  logic [7:0] mem_address, mem_write_data;
  logic       mem_read, mem_write;
  logic [7:0] mem_read_data;
  logic       busy, done;
  logic [7:0] max_value, max_index;

  logic       mem_clr;
  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_scan_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .count          (count),
    .result_addr    (result_addr),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_gnt        (cpu_gnt),
    .cpu_rdata      (cpu_rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data),
    .busy           (busy),
    .done           (done),
    .max_value      (max_value),
    .max_index      (max_index)
  );

  // Data memory: combinational read, write on the rising edge, bulk clear on request.
  always_ff @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
    end else if (mem_write) begin
      mem[mem_address] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_read = 1'b0; cpu_addr = a; cpu_wdata = d;
    tick;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = 8'd0; cpu_wdata = 8'd0;
  endtask

  // Runs one scan from cycle 0; optional CPU stall window and a repeated start at restart_at.
  task automatic scan(input logic [7:0] b, input logic [7:0] c, input logic [7:0] r,
                      input int stall_at, input int stall_len, input int restart_at,
                      output int done_cyc, output int ndone);
    int cyc;
    base_addr = b; count = c; result_addr = r; start = 1'b1;
    cyc = 0; done_cyc = -1; ndone = 0;
    while (cyc < 60 && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
      tick;
      cyc++;
      start = (cyc == restart_at);
      if (stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len) begin
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_read = 1'b0; cpu_addr = 8'd150; cpu_wdata = 8'h99;
        #1;
        chk("stall_addr", 32'(mem_address), 150);
        chk("stall_wdata", 32'(mem_write_data), 32'h99);
        chk("stall_rd", 32'(mem_read), 0);
        chk("stall_busy", 32'(busy), 1);
      end else begin
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = 8'd0; cpu_wdata = 8'd0;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) chk("idle_after_done", 32'(busy), 0);
    end
    start = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0;
  endtask

  initial begin
    int dc, nd;
    rst = 1'b1; mem_clr = 1'b1; start = 1'b0;
    base_addr = 8'd0; count = 8'd0; result_addr = 8'd0;
    cpu_req = 1'b0; cpu_addr = 8'd0; cpu_wdata = 8'd0; cpu_read = 1'b0; cpu_write = 1'b0;
    tick;
    tick;
    mem_clr = 1'b0;

    // Reset values
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_max_value", 32'(max_value), 0);
    chk("rst_max_index", 32'(max_index), 0);
    chk("rst_mem_rd", 32'(mem_read), 0);
    chk("rst_mem_wr", 32'(mem_write), 0);
    chk("rst_mem_addr", 32'(mem_address), 0);
    chk("rst_mem_wdata", 32'(mem_write_data), 0);
    chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
    rst = 1'b0;
    tick;

    // Preload through the CPU path
    cpu_wr(8'd106, 8'h15); cpu_wr(8'd107, 8'h14); cpu_wr(8'd108, 8'h1D); cpu_wr(8'd109, 8'h11);
    cpu_wr(8'd110, 8'h14); cpu_wr(8'd111, 8'h35); cpu_wr(8'd112, 8'hF5);

    // CPU read pass-through in IDLE
    cpu_req = 1'b1; cpu_read = 1'b1; cpu_addr = 8'd111;
    #1;
    chk("cpu_gnt", 32'(cpu_gnt), 1);
    chk("cpu_mem_rd", 32'(mem_read), 1);
    chk("cpu_mem_addr", 32'(mem_address), 111);
    chk("cpu_rdata", 32'(cpu_rdata), 32'h35);
    cpu_req = 1'b0; cpu_read = 1'b0; cpu_addr = 8'd0;
    #1;
    chk("cpu_gnt_off", 32'(cpu_gnt), 0);
    tick;

    // Max scan
    scan(8'd106, 8'd7, 8'd200, 0, 0, 0, dc, nd);
    chk("max_done_cyc", 32'(dc), 10);
    chk("max_ndone", 32'(nd), 1);
    chk("max_value", 32'(max_value), 32'hF5);
    chk("max_index", 32'(max_index), 112);
    chk("max_mem200", 32'(mem[200]), 32'hF5);
    chk("max_mem201", 32'(mem[201]), 32'h70);

    // Tie keeps earliest address
    cpu_wr(8'd50, 8'h40); cpu_wr(8'd51, 8'h10); cpu_wr(8'd52, 8'h40);
    scan(8'd50, 8'd3, 8'd210, 0, 0, 0, dc, nd);
    chk("tie_done_cyc", 32'(dc), 6);
    chk("tie_max_value", 32'(max_value), 32'h40);
    chk("tie_max_index", 32'(max_index), 50);
    chk("tie_mem211", 32'(mem[211]), 50);

    // Contention: CPU holds the port for cycles 4..6
    scan(8'd106, 8'd7, 8'd202, 4, 3, 0, dc, nd);
    chk("cont_done_cyc", 32'(dc), 13);
    chk("cont_ndone", 32'(nd), 1);
    chk("cont_max_value", 32'(max_value), 32'hF5);
    chk("cont_max_index", 32'(max_index), 112);
    chk("cont_mem202", 32'(mem[202]), 32'hF5);
    chk("cont_mem203", 32'(mem[203]), 32'h70);
    chk("cont_mem150", 32'(mem[150]), 32'h99);

    // Start while busy is ignored
    scan(8'd106, 8'd7, 8'd204, 0, 0, 4, dc, nd);
    chk("rebusy_done_cyc", 32'(dc), 10);
    chk("rebusy_ndone", 32'(nd), 1);
    chk("rebusy_mem205", 32'(mem[205]), 32'h70);

    // Reset mid-scan
    base_addr = 8'd106; count = 8'd7; result_addr = 8'd220; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    chk("mid_max_value", 32'(max_value), 32'h15);
    chk("mid_max_index", 32'(max_index), 106);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_max_value", 32'(max_value), 0);
    chk("rstmid_max_index", 32'(max_index), 0);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (done) nd++;
    end
    chk("rstmid_no_done", 32'(nd), 0);
    chk("rstmid_mem220", 32'(mem[220]), 0);
    chk("rstmid_mem221", 32'(mem[221]), 0);
    scan(8'd106, 8'd7, 8'd220, 0, 0, 0, dc, nd);
    chk("after_rst_done_cyc", 32'(dc), 10);
    chk("after_rst_mem220", 32'(mem[220]), 32'hF5);
    chk("after_rst_mem221", 32'(mem[221]), 32'h70);

    // Wrap-around scan over cleared memory
    mem_clr = 1'b1;
    tick;
    mem_clr = 1'b0;
    cpu_wr(8'd100, 8'hAA); cpu_wr(8'd101, 8'hAA); cpu_wr(8'd102, 8'hAA); cpu_wr(8'd103, 8'hAA);
    scan(8'd254, 8'd4, 8'd100, 0, 0, 0, dc, nd);
    chk("wrap_done_cyc", 32'(dc), 7);
    chk("wrap_max_value", 32'(max_value), 0);
    chk("wrap_max_index", 32'(max_index), 254);
    chk("wrap_mem100", 32'(mem[100]), 0);
    chk("wrap_mem101", 32'(mem[101]), 254);

    // Empty scan
    scan(8'd77, 8'd0, 8'd102, 0, 0, 0, dc, nd);
    chk("empty_done_cyc", 32'(dc), 3);
    chk("empty_max_index", 32'(max_index), 77);
    chk("empty_mem102", 32'(mem[102]), 0);
    chk("empty_mem103", 32'(mem[103]), 77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
